// File: rtl/updn_counter_gen.sv
// Parametrised up/down counter: clamped load, programmable step, wrap or saturate in [MIN_VAL, MAX_VAL].
// Define COUNTER_SVA_EN to compile in the embedded self-check assertions.
module updn_counter_gen #(
    parameter int WIDTH   = 8,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 2**WIDTH - 1,
    parameter int SAT     = 0
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             ld_cnt_,
    input  logic             updn_cnt,
    input  logic             count_enb,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] data_out,
    output logic             tc,
    output logic             ovf,
    output logic             udf
);

    localparam logic [WIDTH:0]   MIN_E   = (WIDTH+1)'(MIN_VAL);
    localparam logic [WIDTH:0]   MAX_E   = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   RANGE_E = (WIDTH+1)'(MAX_VAL - MIN_VAL + 1);
    localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);

    if (WIDTH < 2 || MIN_VAL < 0 || MIN_VAL >= MAX_VAL || MAX_VAL > 2**WIDTH - 1) begin : g_bad_params
        $error("updn_counter_gen: illegal WIDTH/MIN_VAL/MAX_VAL combination");
    end

    logic [WIDTH:0]   cur_ext;
    logic [WIDTH:0]   step_ext;
    logic [WIDTH:0]   eff_step;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   dn_floor;
    logic             ovf_evt;
    logic             udf_evt;
    logic             ovf_set;
    logic             udf_set;
    logic [WIDTH-1:0] next_cnt;
    logic [WIDTH-1:0] load_val;
    logic             below_min;
    logic             above_max;

    // Bound checks vanish when the range touches the natural limits of the width.
    if (MIN_VAL > 0) begin : g_lo_chk
        assign below_min = data_in < MIN_W;
    end else begin : g_lo_none
        assign below_min = 1'b0;
    end

    if (MAX_VAL < 2**WIDTH - 1) begin : g_hi_chk
        assign above_max = data_in > MAX_W;
    end else begin : g_hi_none
        assign above_max = 1'b0;
    end

    assign load_val = below_min ? MIN_W : (above_max ? MAX_W : data_in);

    // Underflow is tested as cur < MIN+s so the extended arithmetic never goes negative.
    always_comb begin
        cur_ext  = {1'b0, data_out};
        step_ext = {1'b0, step};
        eff_step = (step_ext > RANGE_E) ? RANGE_E : step_ext;
        up_sum   = cur_ext + eff_step;
        dn_floor = MIN_E + eff_step;
        ovf_evt  = updn_cnt && (up_sum > MAX_E);
        udf_evt  = !updn_cnt && (cur_ext < dn_floor);
        next_cnt = data_out;
        if (updn_cnt) begin
            if (!ovf_evt)
                next_cnt = WIDTH'(up_sum);
            else if (SAT != 0)
                next_cnt = MAX_W;
            else
                next_cnt = WIDTH'(up_sum - RANGE_E);
        end else begin
            if (!udf_evt)
                next_cnt = WIDTH'(cur_ext - eff_step);
            else if (SAT != 0)
                next_cnt = MIN_W;
            else
                next_cnt = WIDTH'(cur_ext + RANGE_E - eff_step);
        end
    end

    assign ovf_set = ld_cnt_ && count_enb && ovf_evt;
    assign udf_set = ld_cnt_ && count_enb && udf_evt;

    always_ff @(posedge clk) begin
        if (!rst_) begin
            data_out <= MIN_W;
            tc       <= 1'b0;
            ovf      <= 1'b0;
            udf      <= 1'b0;
        end else begin
            if (!ld_cnt_)
                data_out <= load_val;
            else if (count_enb)
                data_out <= next_cnt;
            tc  <= ovf_set || udf_set;
            ovf <= ovf_set || (ovf && !clr_flags);
            udf <= udf_set || (udf && !clr_flags);
        end
    end

`ifdef COUNTER_SVA_EN
    a_reset: assert property (@(posedge clk)
        !rst_ |=> (data_out == MIN_W && !tc && !ovf && !udf))
        else $error("%0t reset: data_out=%0d tc=%b ovf=%b udf=%b", $stime, data_out, tc, ovf, udf);

    a_hold: assert property (@(posedge clk) disable iff (!rst_)
        (ld_cnt_ && !count_enb) |=> $stable(data_out))
        else $error("%0t hold: data_out=%0d was=%0d", $stime, data_out, $past(data_out));

    a_up: assert property (@(posedge clk) disable iff (!rst_)
        (ld_cnt_ && count_enb && updn_cnt) |=>
        ({1'b0, data_out} == ($past(ovf_evt) ? ((SAT != 0) ? MAX_E : $past(up_sum) - RANGE_E)
                                             : $past(up_sum))))
        else $error("%0t up: data_out=%0d prev=%0d step=%0d", $stime, data_out, $past(data_out), $past(step));

    a_down: assert property (@(posedge clk) disable iff (!rst_)
        (ld_cnt_ && count_enb && !updn_cnt) |=>
        ({1'b0, data_out} == ($past(udf_evt)
            ? ((SAT != 0) ? MIN_E : $past(cur_ext) + RANGE_E - $past(eff_step))
            : $past(cur_ext) - $past(eff_step))))
        else $error("%0t down: data_out=%0d prev=%0d step=%0d", $stime, data_out, $past(data_out), $past(step));

    a_load: assert property (@(posedge clk) disable iff (!rst_)
        !ld_cnt_ |=> (data_out == $past(load_val)))
        else $error("%0t load: data_out=%0d data_in=%0d", $stime, data_out, $past(data_in));

    a_range: assert property (@(posedge clk) disable iff (!rst_)
        ({1'b0, data_out} >= MIN_E && {1'b0, data_out} <= MAX_E))
        else $error("%0t range: data_out=%0d", $stime, data_out);

    a_tc: assert property (@(posedge clk) disable iff (!rst_)
        tc |-> $past(ovf_set || udf_set))
        else $error("%0t tc: tc=%b without a counting event", $stime, tc);
`endif

endmodule

// File: tb/tb_updn_counter_gen.sv
// Bench for updn_counter_gen: wrap and saturate instances driven in parallel, checked
// against an integer model of the counting rules (directed steps, then random cycles).
module tb_updn_counter_gen;

    localparam int WIDTH   = 8;
    localparam int MIN_VAL = 10;
    localparam int MAX_VAL = 200;
    localparam int RANGE   = MAX_VAL - MIN_VAL + 1;

    logic             clk = 1'b0;
    logic             rst_;
    logic             ld_cnt_;
    logic             updn_cnt;
    logic             count_enb;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] data_in;
    logic             clr_flags;

    logic [WIDTH-1:0] dout_w;
    logic             tc_w;
    logic             ovf_w;
    logic             udf_w;
    logic [WIDTH-1:0] dout_s;
    logic             tc_s;
    logic             ovf_s;
    logic             udf_s;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state, index 0 = wrap instance, 1 = saturate instance.
    int m_val [2];
    int m_tc  [2];
    int m_ovf [2];
    int m_udf [2];

    updn_counter_gen #(.WIDTH(WIDTH), .MIN_VAL(MIN_VAL), .MAX_VAL(MAX_VAL), .SAT(0)) dut_wrap (
        .clk(clk), .rst_(rst_), .ld_cnt_(ld_cnt_), .updn_cnt(updn_cnt), .count_enb(count_enb),
        .step(step), .data_in(data_in), .clr_flags(clr_flags),
        .data_out(dout_w), .tc(tc_w), .ovf(ovf_w), .udf(udf_w)
    );

    updn_counter_gen #(.WIDTH(WIDTH), .MIN_VAL(MIN_VAL), .MAX_VAL(MAX_VAL), .SAT(1)) dut_sat (
        .clk(clk), .rst_(rst_), .ld_cnt_(ld_cnt_), .updn_cnt(updn_cnt), .count_enb(count_enb),
        .step(step), .data_in(data_in), .clr_flags(clr_flags),
        .data_out(dout_s), .tc(tc_s), .ovf(ovf_s), .udf(udf_s)
    );

    always #5 clk = ~clk;

    task automatic model_update();
        int v;
        int s;
        int up_evt;
        int dn_evt;
        for (int i = 0; i < 2; i++) begin
            if (!rst_) begin
                m_val[i] = MIN_VAL;
                m_tc[i]  = 0;
                m_ovf[i] = 0;
                m_udf[i] = 0;
            end else begin
                up_evt = 0;
                dn_evt = 0;
                if (!ld_cnt_) begin
                    v = int'(data_in);
                    if (v < MIN_VAL) v = MIN_VAL;
                    if (v > MAX_VAL) v = MAX_VAL;
                    m_val[i] = v;
                end else if (count_enb) begin
                    s = (int'(step) > RANGE) ? RANGE : int'(step);
                    if (updn_cnt) begin
                        v = m_val[i] + s;
                        if (v > MAX_VAL) begin
                            up_evt = 1;
                            v = (i == 1) ? MAX_VAL : v - RANGE;
                        end
                    end else begin
                        v = m_val[i] - s;
                        if (v < MIN_VAL) begin
                            dn_evt = 1;
                            v = (i == 1) ? MIN_VAL : v + RANGE;
                        end
                    end
                    m_val[i] = v;
                end
                if (clr_flags) begin
                    m_ovf[i] = 0;
                    m_udf[i] = 0;
                end
                if (up_evt != 0) m_ovf[i] = 1;
                if (dn_evt != 0) m_udf[i] = 1;
                m_tc[i] = up_evt | dn_evt;
            end
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input int expected);
        checks++;
        assert (observed === 32'(expected))
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic compare_all();
        check_output($sformatf("wrap.data_out c%0d", cyc), 32'(dout_w), m_val[0]);
        check_output($sformatf("wrap.tc c%0d", cyc),       32'(tc_w),   m_tc[0]);
        check_output($sformatf("wrap.ovf c%0d", cyc),      32'(ovf_w),  m_ovf[0]);
        check_output($sformatf("wrap.udf c%0d", cyc),      32'(udf_w),  m_udf[0]);
        check_output($sformatf("sat.data_out c%0d", cyc),  32'(dout_s), m_val[1]);
        check_output($sformatf("sat.tc c%0d", cyc),        32'(tc_s),   m_tc[1]);
        check_output($sformatf("sat.ovf c%0d", cyc),       32'(ovf_s),  m_ovf[1]);
        check_output($sformatf("sat.udf c%0d", cyc),       32'(udf_s),  m_udf[1]);
    endtask

    // One clock: drive inputs, advance the model on the edge, compare just after it.
    task automatic apply_stimulus(input logic r, input logic l, input logic u, input logic e,
                                  input int st, input int din, input logic c);
        rst_      = r;
        ld_cnt_   = l;
        updn_cnt  = u;
        count_enb = e;
        step      = WIDTH'(st);
        data_in   = WIDTH'(din);
        clr_flags = c;
        @(posedge clk);
        model_update();
        cyc++;
        #1;
        compare_all();
    endtask

    initial begin
        // Reset while load and count are also requested.
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 0, 123, 1'b0);
        // Clamped loads.
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1, 0, 250, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 0, 3, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 0, 99, 1'b0);
        // Up across MAX_VAL, then a hold to see tc drop while ovf sticks.
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 0, 198, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 5, 0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 5, 0, 1'b0);
        // Down across MIN_VAL twice; saturate instance fires on both.
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 12, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 5, 0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 5, 0, 1'b0);
        // Four hold cycles with noisy data/step.
        for (int k = 0; k < 4; k++)
            apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 7, 55, 1'b0);
        // Load beats count.
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1, 9, 77, 1'b0);
        // Flag clear, then clear colliding with a fresh overflow.
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b1);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 0, 200, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 1, 0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b1);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 0, 200, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 1, 0, 1'b1);
        // Step larger than the range, then a zero step.
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 0, 100, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 255, 0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
        // Reset in the middle of counting.
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 3, 0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 9, 150, 1'b1);
        // Random traffic, mostly counting with small steps so both bounds get hit.
        for (int k = 0; k < 400; k++) begin
            apply_stimulus($urandom_range(0, 39) != 0,
                           $urandom_range(0, 7) == 0 ? 1'b0 : 1'b1,
                           $urandom_range(0, 1) == 1,
                           $urandom_range(0, 3) != 0,
                           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                                       : int'($urandom_range(0, 12)),
                           int'($urandom_range(0, 255)),
                           $urandom_range(0, 7) == 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
